// File: rtl/sc_s2b_decoder.sv
// ---------------------------------------------------------------------------
// sc_s2b_decoder
//   Stochastic-to-binary decoder. It counts the ones in a unipolar or bipolar
//   bitstream over a fixed window of 2^WIDTH samples. At the end of each window
//   it outputs the binary estimate together with a one-cycle valid pulse.
//
//   Parameters
//     WIDTH    result width; the window is 2^WIDTH samples long
//     BIPOLAR  0: unsigned count, 1: two's-complement (count - 2^(WIDTH-1))
//
//   Ports
//     clk        clock, rising edge
//     rst_n      asynchronous reset, active low
//     start      begin a window (sampled only in IDLE)
//     cont       continuous mode, sampled on the final sample edge
//     bitstream  stochastic input bit, one sample per cycle in RUN
//     busy       high while a window is being collected
//     result     decoded value, held until the next valid
//     valid      one-cycle pulse when result updates
// ---------------------------------------------------------------------------
module sc_s2b_decoder #(
    parameter int WIDTH   = 4,
    parameter bit BIPOLAR = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    input  logic             bitstream,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             valid
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH:0]     r_acc;
    logic [WIDTH-1:0]   r_wcnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_valid;

    logic               w_last;
    logic               w_start_win;
    logic [WIDTH:0]     w_count;
    logic [WIDTH-1:0]   w_decoded;

    assign w_last      = (r_state == RUN) && (r_wcnt == {WIDTH{1'b1}});
    assign w_start_win = (r_state == IDLE) && start;
    // The final sample is included in the count. The WIDTH+1 bit width holds 2^WIDTH.
    assign w_count     = r_acc + {{WIDTH{1'b0}}, bitstream};

    // A full count of 2^WIDTH cannot be represented in WIDTH bits, so it
    // saturates to the largest value. In bipolar mode, subtracting
    // 2^(WIDTH-1) modulo 2^WIDTH is the same as inverting the MSB.
    always_comb begin
        w_decoded = w_count[WIDTH-1:0];
        if (w_count[WIDTH]) begin
            w_decoded = BIPOLAR ? {1'b0, {(WIDTH-1){1'b1}}} : {WIDTH{1'b1}};
        end else if (BIPOLAR) begin
            w_decoded[WIDTH-1] = ~w_count[WIDTH-1];
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = RUN;
            RUN:     if (w_last && !cont) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_wcnt   <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_start_win) begin
                r_acc  <= '0;
                r_wcnt <= '0;
            end else if (r_state == RUN) begin
                if (w_last) begin
                    // Clearing here lets the next edge take sample 0 of the
                    // following window when cont=1, so there is no gap.
                    r_result <= w_decoded;
                    r_valid  <= 1'b1;
                    r_acc    <= '0;
                    r_wcnt   <= '0;
                end else begin
                    r_acc  <= w_count;
                    r_wcnt <= r_wcnt + 1'b1;
                end
            end
        end
    end

    assign busy   = (r_state == RUN);
    assign result = r_result;
    assign valid  = r_valid;

endmodule
